eth_frame_filter: RTL and testbench

Store-and-forward filter directly downstream of the Ethernet frame parser. Each frame's beats are buffered speculatively in an internal RAM. When the frame's tlast has been accepted and its parsed metadata has arrived, the block commits the frame to the output or discards it by rolling back the write pointer. The verdict comes from the protocol class, destination MAC and VLAN ID. Only committed frames are presented on the egress AXI stream, so downstream never sees a dropped frame.

---
 rtl/eth_frame_filter.sv | 185 ++++++++++++++++++
 tb/tb_eth_frame_filter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_filter.sv
// Store-and-forward Ethernet frame filter: frames are buffered speculatively and then
// committed to egress or rolled back once the parser's metadata verdict is known.
module eth_frame_filter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_meta_valid,
  input  logic [47:0]           s_meta_dest_mac,
  input  logic [3:0]            s_meta_proto,
  input  logic                  s_meta_vlan_present,
  input  logic [11:0]           s_meta_vlan_id,
  input  logic [3:0]            cfg_proto_allow,
  input  logic                  cfg_mac_en,
  input  logic [47:0]           cfg_mac_addr,
  input  logic                  cfg_vlan_en,
  input  logic [11:0]           cfg_vlan_id,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [31:0]           stat_pass_cnt,
  output logic [31:0]           stat_drop_cnt,
  output logic                  meta_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {StRecv, StWaitMeta, StVerdict} state_t;

  state_t          state;
  logic [PW-1:0]   wr_ptr, wr_commit, rd_ptr;
  logic            trunc;
  logic            meta_full;
  logic [47:0]     meta_dest;
  logic [3:0]      meta_proto;
  logic            meta_vlan_present;
  logic [11:0]     meta_vlan_id;

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [DATA_WIDTH:0] ram_q;
  logic [DATA_WIDTH:0] ent0, ent1;
  logic [1:0]          out_cnt;
  logic                rd_pend;

  logic [PW-1:0] used;
  logic          full, in_acc, wr_en, rd_en, pop;
  logic          mac_ok, vlan_ok, pass;
  logic [2:0]    nxt_cnt;

  always_comb begin
    used    = wr_ptr - rd_ptr;
    full    = (used == PW'(DEPTH));
    in_acc  = s_axis_tvalid && s_axis_tready;
    wr_en   = in_acc && !full;
    mac_ok  = !cfg_mac_en || (meta_dest == cfg_mac_addr) || (meta_dest == 48'hFFFF_FFFF_FFFF);
    vlan_ok = !cfg_vlan_en || (meta_vlan_present && (meta_vlan_id == cfg_vlan_id));
    pass    = (|(meta_proto & cfg_proto_allow)) && mac_ok && vlan_ok && !trunc;
  end

  // Write FSM: speculative writes, then commit or roll back in the single VERDICT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= StRecv;
      s_axis_tready <= 1'b0;
      wr_ptr        <= '0;
      wr_commit     <= '0;
      trunc         <= 1'b0;
      stat_pass_cnt <= '0;
      stat_drop_cnt <= '0;
    end else begin
      case (state)
        StRecv: begin
          s_axis_tready <= 1'b1;
          if (in_acc) begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            else       trunc  <= 1'b1;
            if (s_axis_tlast) begin
              s_axis_tready <= 1'b0;
              state         <= (meta_full || s_meta_valid) ? StVerdict : StWaitMeta;
            end
          end
        end
        StWaitMeta: begin
          s_axis_tready <= 1'b0;
          if (meta_full) state <= StVerdict;
        end
        StVerdict: begin
          if (pass) begin
            wr_commit <= wr_ptr;
            if (stat_pass_cnt != 32'hFFFF_FFFF) stat_pass_cnt <= stat_pass_cnt + 32'd1;
          end else begin
            wr_ptr <= wr_commit;
            if (stat_drop_cnt != 32'hFFFF_FFFF) stat_drop_cnt <= stat_drop_cnt + 32'd1;
          end
          trunc         <= 1'b0;
          s_axis_tready <= 1'b1;
          state         <= StRecv;
        end
        default: begin
          s_axis_tready <= 1'b0;
          state         <= StRecv;
        end
      endcase
    end
  end

  // A pulse landing in the VERDICT cycle belongs to the next frame, so it wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_full         <= 1'b0;
      meta_dest         <= '0;
      meta_proto        <= '0;
      meta_vlan_present <= 1'b0;
      meta_vlan_id      <= '0;
      meta_overflow     <= 1'b0;
    end else begin
      meta_overflow <= s_meta_valid && meta_full && (state != StVerdict);
      if (s_meta_valid && (!meta_full || state == StVerdict)) begin
        meta_full         <= 1'b1;
        meta_dest         <= s_meta_dest_mac;
        meta_proto        <= s_meta_proto;
        meta_vlan_present <= s_meta_vlan_present;
        meta_vlan_id      <= s_meta_vlan_id;
      end else if (state == StVerdict) begin
        meta_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    if (rd_en) ram_q <= mem[rd_ptr[AW-1:0]];
  end

  // Issue a read only if the 2-entry output stage is guaranteed room when the data lands.
  always_comb begin
    pop     = m_axis_tvalid && m_axis_tready;
    nxt_cnt = 3'(out_cnt) + 3'(rd_pend) - 3'(pop);
    rd_en   = (rd_ptr != wr_commit) && (nxt_cnt <= 3'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
      out_cnt <= '0;
      ent0    <= '0;
      ent1    <= '0;
    end else begin
      rd_pend <= rd_en;
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      out_cnt <= nxt_cnt[1:0];
      case ({rd_pend, pop})
        2'b10: begin
          if (out_cnt == 2'd0) ent0 <= ram_q;
          else                 ent1 <= ram_q;
        end
        2'b01: ent0 <= ent1;
        2'b11: begin
          if (out_cnt == 2'd1) begin
            ent0 <= ram_q;
          end else begin
            ent0 <= ent1;
            ent1 <= ram_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    m_axis_tvalid = (out_cnt != 2'd0);
    m_axis_tdata  = ent0[DATA_WIDTH-1:0];
    m_axis_tlast  = ent0[DATA_WIDTH];
  end

endmodule

// File: tb/tb_eth_frame_filter.sv
// Scoreboard bench for eth_frame_filter: a frame-level model predicts pass/drop and the
// egress beat sequence; a negedge monitor pops and compares every egress handshake.
module tb_eth_frame_filter;
  localparam int DW    = 64;
  localparam int DEPTH = 16;

  typedef struct {
    logic [47:0] dest;
    logic [3:0]  proto;
    logic        vp;
    logic [11:0] vid;
  } meta_t;

  typedef struct {
    logic [3:0]  allow;
    logic        mac_en;
    logic [47:0] mac;
    logic        vlan_en;
    logic [11:0] vid;
  } cfg_t;

  logic          clk, rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic          s_meta_valid;
  logic [47:0]   s_meta_dest_mac;
  logic [3:0]    s_meta_proto;
  logic          s_meta_vlan_present;
  logic [11:0]   s_meta_vlan_id;
  logic [3:0]    cfg_proto_allow;
  logic          cfg_mac_en;
  logic [47:0]   cfg_mac_addr;
  logic          cfg_vlan_en;
  logic [11:0]   cfg_vlan_id;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [31:0]   stat_pass_cnt, stat_drop_cnt;
  logic          meta_overflow;

  eth_frame_filter #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_meta_valid(s_meta_valid), .s_meta_dest_mac(s_meta_dest_mac),
    .s_meta_proto(s_meta_proto), .s_meta_vlan_present(s_meta_vlan_present),
    .s_meta_vlan_id(s_meta_vlan_id),
    .cfg_proto_allow(cfg_proto_allow), .cfg_mac_en(cfg_mac_en), .cfg_mac_addr(cfg_mac_addr),
    .cfg_vlan_en(cfg_vlan_en), .cfg_vlan_id(cfg_vlan_id),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .stat_pass_cnt(stat_pass_cnt), .stat_drop_cnt(stat_drop_cnt),
    .meta_overflow(meta_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [DW:0] exp_q[$];
  int pass_exp = 0, drop_exp = 0, ovf_seen = 0, ovf_exp = 0;
  bit rand_ready = 0;
  logic [DW:0] held;
  bit holding = 0;

  task automatic check(string name, logic [DW:0] act, logic [DW:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  always @(posedge clk) begin
    #1;
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: handshake seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      holding = 0;
    end else begin
      if (holding) begin
        check("stall_valid_held", 65'(m_axis_tvalid), 65'(1));
        check("stall_data_stable", {m_axis_tlast, m_axis_tdata}, held);
      end
      holding = 0;
      if (m_axis_tvalid) begin
        if (m_axis_tready) begin
          if (exp_q.size() == 0) fail_now("unexpected_egress_beat");
          else check("egress_beat", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
        end else begin
          holding = 1;
          held = {m_axis_tlast, m_axis_tdata};
        end
      end
      if (meta_overflow) ovf_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic bit model_pass(cfg_t c, meta_t m, int len);
    bit proto_ok = (m.proto & c.allow) != 4'd0;
    bit mac_ok   = !c.mac_en || m.dest == c.mac || m.dest == {48{1'b1}};
    bit vlan_ok  = !c.vlan_en || (m.vp && m.vid == c.vid);
    return proto_ok && mac_ok && vlan_ok && (len <= DEPTH);
  endfunction

  task automatic apply_meta(meta_t m);
    s_meta_dest_mac     = m.dest;
    s_meta_proto        = m.proto;
    s_meta_vlan_present = m.vp;
    s_meta_vlan_id      = m.vid;
  endtask

  task automatic apply_cfg(cfg_t c);
    cfg_proto_allow = c.allow;
    cfg_mac_en      = c.mac_en;
    cfg_mac_addr    = c.mac;
    cfg_vlan_en     = c.vlan_en;
    cfg_vlan_id     = c.vid;
  endtask

  // Returns at posedge+1 after ingress was seen ready; the DUT is then idle in RECV.
  task automatic wait_ready();
    int n = 0;
    bit rdy;
    do begin
      @(negedge clk);
      rdy = s_axis_tready;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) fail_now("ingress_ready_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_room(int len);
    int n = 0;
    while (exp_q.size() + len > DEPTH && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() + len > DEPTH) fail_now("room_timeout");
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    repeat (8) @(posedge clk);
    #1;
  endtask

  // mode 0: meta on tlast beat; 1: meta before first beat; 2: meta 'delay' cycles after
  // tlast; 3: meta already latched by the caller.
  task automatic send_frame(int len, cfg_t c, meta_t m, int mode, int delay, output int stalls);
    logic [DW:0] beats[$];
    logic [DW-1:0] d;
    bit rdy;
    int n;
    stalls = 0;
    for (int i = 0; i < len; i++) begin
      d = {$urandom(), $urandom()};
      beats.push_back({(i == len - 1), d});
    end
    if (len <= DEPTH) wait_room(len);
    wait_ready();
    apply_cfg(c);
    if (model_pass(c, m, len)) begin
      foreach (beats[i]) exp_q.push_back(beats[i]);
      pass_exp++;
    end else begin
      drop_exp++;
    end
    if (mode == 1) begin
      apply_meta(m);
      s_meta_valid = 1'b1;
      @(posedge clk);
      #1;
      s_meta_valid = 1'b0;
    end
    for (int i = 0; i < len; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = beats[i][DW-1:0];
      s_axis_tlast  = beats[i][DW];
      if (mode == 0 && i == len - 1) begin
        apply_meta(m);
        s_meta_valid = 1'b1;
      end
      n = 0;
      do begin
        @(negedge clk);
        rdy = s_axis_tready;
        if (!rdy && i > 0) stalls++;
        @(posedge clk);
        n++;
      end while (!rdy && n < 100);
      if (!rdy) fail_now("beat_accept_timeout");
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_meta_valid  = 1'b0;
    if (mode == 2) begin
      repeat (delay) begin
        @(negedge clk);
        check("tready_low_waiting_meta", 65'(s_axis_tready), 65'(0));
        @(posedge clk);
        #1;
      end
      apply_meta(m);
      s_meta_valid = 1'b1;
      @(posedge clk);
      #1;
      s_meta_valid = 1'b0;
    end
  endtask

  task automatic check_stats(string tag);
    check({tag, "_pass_cnt"}, 65'(stat_pass_cnt), 65'(pass_exp));
    check({tag, "_drop_cnt"}, 65'(stat_drop_cnt), 65'(drop_exp));
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_s_tready"}, 65'(s_axis_tready), 65'(0));
    check({tag, "_m_tvalid"}, 65'(m_axis_tvalid), 65'(0));
    check({tag, "_m_tdata"}, 65'({m_axis_tlast, m_axis_tdata}), 65'(0));
    check({tag, "_pass_cnt"}, 65'(stat_pass_cnt), 65'(0));
    check({tag, "_drop_cnt"}, 65'(stat_drop_cnt), 65'(0));
    check({tag, "_overflow"}, 65'(meta_overflow), 65'(0));
  endtask

  initial begin
    cfg_t c;
    meta_t m, m2;
    int st;
    rst = 1'b1;
    s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = '0;
    s_meta_valid = 0;
    m = '{dest: 48'h0, proto: 4'b0001, vp: 1'b0, vid: 12'h0};
    apply_meta(m);
    c = '{allow: 4'b0001, mac_en: 1'b0, mac: 48'h02_00_00_00_00_01, vlan_en: 1'b0, vid: 12'h0};
    apply_cfg(c);
    m_axis_tready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("in_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("tready_before_first_edge", 65'(s_axis_tready), 65'(0));
    @(negedge clk);
    check("tready_after_first_edge", 65'(s_axis_tready), 65'(1));

    // Basic IPv4 pass, then ARP drop, then IPv4 pass again.
    m.dest = 48'h02_00_00_00_00_05;
    send_frame(3, c, m, 0, 0, st);
    wait_drain();
    check_stats("ipv4_pass");
    m.proto = 4'b0100;
    send_frame(3, c, m, 0, 0, st);
    m.proto = 4'b0001;
    send_frame(3, c, m, 0, 0, st);
    wait_drain();
    check_stats("arp_drop");

    // Destination MAC filtering: local, broadcast, other.
    c.mac_en = 1'b1;
    m.dest = 48'h02_00_00_00_00_01; send_frame(2, c, m, 1, 0, st);
    m.dest = 48'hFF_FF_FF_FF_FF_FF; send_frame(2, c, m, 0, 0, st);
    m.dest = 48'h02_00_00_00_00_02; send_frame(2, c, m, 0, 0, st);
    wait_drain();
    check_stats("mac_filter");
    c.mac_en = 1'b0;

    // Oversized frame is truncated and dropped without stalling ingress.
    send_frame(20, c, m, 0, 0, st);
    check("trunc_no_ingress_stall", 65'(st), 65'(0));
    send_frame(4, c, m, 0, 0, st);
    wait_drain();
    check_stats("truncation");

    // Metadata arrives 5 cycles after tlast.
    send_frame(3, c, m, 2, 5, st);
    wait_drain();
    check_stats("late_meta");

    // Two metadata pulses before tlast: second is lost, first one decides.
    wait_ready();
    apply_cfg(c);
    m.proto = 4'b0001;
    apply_meta(m);
    s_meta_valid = 1'b1;
    @(posedge clk); #1;
    s_meta_valid = 1'b0;
    @(posedge clk); #1;
    m2 = m;
    m2.proto = 4'b0100;
    apply_meta(m2);
    s_meta_valid = 1'b1;
    @(posedge clk); #1;
    s_meta_valid = 1'b0;
    ovf_exp++;
    send_frame(3, c, m, 3, 0, st);
    wait_drain();
    check("meta_overflow_pulses", 65'(ovf_seen), 65'(ovf_exp));
    check_stats("overflow_first_meta");

    // Randomised traffic with random egress backpressure.
    rand_ready = 1;
    for (int f = 0; f < 30; f++) begin
      m.proto = 4'b0001 << $urandom_range(0, 3);
      c.allow = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) c.allow = c.allow | m.proto;
      c.mac_en = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: m.dest = c.mac;
        1: m.dest = 48'hFF_FF_FF_FF_FF_FF;
        default: m.dest = {16'h0200, $urandom()};
      endcase
      c.vlan_en = 1'($urandom_range(0, 1));
      c.vid = 12'($urandom_range(0, 4095));
      m.vp = ($urandom_range(0, 3) != 0);
      m.vid = ($urandom_range(0, 2) != 0) ? c.vid : 12'($urandom_range(0, 4095));
      send_frame($urandom_range(1, 8), c, m, $urandom_range(0, 2), $urandom_range(0, 4), st);
    end
    rand_ready = 0;
    wait_drain();
    check_stats("random_traffic");

    // Reset in the middle of a frame.
    c = '{allow: 4'b0001, mac_en: 1'b0, mac: 48'h02_00_00_00_00_01, vlan_en: 1'b0, vid: 12'h0};
    wait_ready();
    apply_cfg(c);
    repeat (2) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {$urandom(), $urandom()};
      s_axis_tlast  = 1'b0;
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("midreset_s_tready", 65'(s_axis_tready), 65'(0));
    check("midreset_m_tvalid", 65'(m_axis_tvalid), 65'(0));
    check("midreset_pass_cnt", 65'(stat_pass_cnt), 65'(0));
    check("midreset_drop_cnt", 65'(stat_drop_cnt), 65'(0));
    s_axis_tvalid = 1'b0;
    exp_q.delete();
    pass_exp = 0;
    drop_exp = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m.proto = 4'b0001;
    send_frame(4, c, m, 0, 0, st);
    wait_drain();
    check_stats("post_reset");
    check("final_overflow_pulses", 65'(ovf_seen), 65'(ovf_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
